mpsoc_wb_uart_host: RTL and testbench
=====================================

# mpsoc_wb_uart_host

Wishbone initiator that owns a 16550-compatible UART register slave: it programs the UART at start-up, then polls the line status register. It moves bytes between a valid/ready byte-stream interface and the THR/RBR registers. It sits between a local byte producer/consumer (debug or boot logic) and the UART's 8-bit Wishbone slave port, so that logic never has to issue register accesses itself.

## Interface
- DIVISOR, 16'd27, baud divisor written to DLL/DLM
- LCR_VALUE, 8'h03, line control value (8N1); DLAB bit 7 must be 0
- ACK_TIMEOUT, 255, cycles allowed per transfer before abort (1..255)
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_ni  in  1  reset, asynchronous assertion, active-low
- wb_adr_o  out  3  UART register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data, sampled on the ack cycle
- wb_we_o  out  1  write enable
- wb_stb_o / wb_cyc_o  out  1 each  strobe / cycle, always driven equal
- wb_sel_o  out  4  constant 4'b0001
- wb_ack_i  in  1  slave acknowledge
- tx_data_i  in  8  byte to transmit; held stable while tx_valid_i is high
- tx_valid_i  in  1  transmit request
- tx_ready_o  out  1  one-cycle pulse: byte consumed
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx_data_o valid; held until rx_ready_i
- rx_ready_i  in  1  consumer accepts the byte
- init_done_o  out  1  UART configuration complete
- err_o  out  1  sticky: a transfer timed out

## Operation
- Reset: all outputs 0 except wb_sel_o=4'b0001. FSM enters INIT at step 0.
- INIT performs six writes in order:
  - addr 3 = LCR_VALUE|8'h80
  - addr 0 = DIVISOR[7:0]
  - addr 1 = DIVISOR[15:8]
  - addr 3 = LCR_VALUE
  - addr 2 = 8'h07 (FCR: enable and clear FIFOs)
  - addr 1 = 8'h00 (IER)
- After the last write is acked, init_done_o goes to 1 and the FSM enters POLL.
- POLL reads addr 5 (LSR) and latches the returned value into lsr_q.
- RX_RD: entered if lsr_q[0]=1 and rx_valid_o=0. Reads addr 0. On ack, rx_data_o takes wb_dat_i and rx_valid_o goes to 1.
- TX_WR: entered after RX_RD, or directly from POLL, if lsr_q[5]=1 and tx_valid_i=1. Writes tx_data_i to addr 0. On ack, tx_ready_o pulses.
- A single LSR sample can therefore serve one RX read and then one TX write, so neither direction starves. After either, or if neither is eligible, the FSM returns to POLL.
- rx_valid_o clears in the cycle after rx_valid_o&rx_ready_i. While it is set, no RBR read is issued and the UART FIFO absorbs incoming bytes.
- tx_valid_i falling before tx_ready_o is a protocol violation by the producer. The data latched at issue is written regardless.
- Timeout: a per-transfer counter starts at issue. If no ack arrives within ACK_TIMEOUT cycles:
  - cyc/stb drop and err_o is set.
  - A timed-out read returns 8'h00. A timed-out INIT write advances to the next step. A timed-out TX write still pulses tx_ready_o, so the byte is dropped.
  - Operation continues. err_o clears only on reset.

## Timing
- Issue: cyc/stb/adr/dat/we register high at edge N. The slave may ack at any cycle ≥N+1. wb_ack_i is ignored while stb=0.
- Ack sampled at edge M: cyc/stb are low after M and stay low for at least one cycle, so the minimum transfer period is 2 cycles plus ack latency.
- adr/dat/we hold constant from issue until the transfer completes.
- tx_ready_o and the rx_valid_o rise register on the ack edge.
- Reset asserted mid-transfer: cyc/stb drop immediately (asynchronously) and INIT restarts at step 0 on release. The in-flight byte is neither acknowledged nor delivered.
- Minimum init duration with single-cycle ack: 6×2 = 12 cycles.

## Structure
- Package mpsoc_uart_wb_pkg gains:
  - register address constants: RBR/THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, LSR=5
  - LSR bit indices: DR=0, THRE=5
  - FCR init value 8'h07
  - host FSM state enum: INIT, POLL, RX_RD, TX_WR
- Sub-module mpsoc_wb_uart_host_port owns the Wishbone single-transfer engine: req/we/adr/dat in, done/rdata/timeout out, the cyc/stb/ack handshake, the idle gap and the timeout counter.
- The top-level FSM sequences register accesses through mpsoc_wb_uart_host_port.

## Test plan
- Init, DIVISOR=16'h001B, LCR_VALUE=8'h03, 1-cycle ack: writes (3,83),(0,1B),(1,00),(3,03),(2,07),(1,00) in order; then init_done_o=1 and the next access is a read of addr 5.
- TX: LSR returns 8'h60, tx_data_i=8'h55 valid → write addr 0 data 8'h55; single tx_ready_o pulse on the ack edge.
- RX with backpressure: LSR=8'h01, RBR=8'hA5, rx_ready_i=0 → rx_valid_o=1, rx_data_o=8'hA5. No further addr-0 reads until rx_ready_i=1. Then the next byte 8'h3C is delivered.
- Simultaneous: LSR=8'h61, tx_valid_i=1 → RBR read then THR write from the same LSR sample, then POLL.
- Timeout, ACK_TIMEOUT=8, slave silent → cyc drops 8 cycles after issue, err_o=1 and stays 1, the sequence continues.
- Reset mid-transfer with wb_ack_i held 0 → wb_cyc_o=0 without a clock edge; after release, the first access is (3,83).

Source files
------------

// File: rtl/mpsoc_uart_wb_pkg.sv
// mpsoc_uart_wb_pkg: UART register map, LSR bits, host FSM states and init sequence table
package mpsoc_uart_wb_pkg;

    localparam logic [2:0] ADR_RBR = 3'd0;
    localparam logic [2:0] ADR_THR = 3'd0;
    localparam logic [2:0] ADR_DLL = 3'd0;
    localparam logic [2:0] ADR_IER = 3'd1;
    localparam logic [2:0] ADR_DLM = 3'd1;
    localparam logic [2:0] ADR_FCR = 3'd2;
    localparam logic [2:0] ADR_LCR = 3'd3;
    localparam logic [2:0] ADR_LSR = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_THRE = 5;

    localparam logic [7:0] FCR_INIT   = 8'h07;
    localparam logic [2:0] INIT_LAST  = 3'd5;

    typedef enum logic [1:0] {ST_INIT, ST_POLL, ST_RX_RD, ST_TX_WR} host_state_t;

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] dat;
    } wb_wr_t;

    // DLAB is raised for the divisor writes, then LCR is rewritten with DLAB clear
    function automatic wb_wr_t init_write(input logic [2:0] step, input logic [15:0] div, input logic [7:0] lcr);
        wb_wr_t w;
        case (step)
            3'd0:    w = {ADR_LCR, lcr | 8'h80};
            3'd1:    w = {ADR_DLL, div[7:0]};
            3'd2:    w = {ADR_DLM, div[15:8]};
            3'd3:    w = {ADR_LCR, lcr};
            3'd4:    w = {ADR_FCR, FCR_INIT};
            default: w = {ADR_IER, 8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mpsoc_wb_uart_host_port.sv
// mpsoc_wb_uart_host_port: single-transfer Wishbone engine with ack timeout
module mpsoc_wb_uart_host_port #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [2:0] i_adr,
    input  logic [7:0] i_dat,
    output logic       o_done,
    output logic       o_timeout,
    output logic [7:0] o_rdata,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    logic       r_cyc;
    logic       r_we;
    logic [2:0] r_adr;
    logic [7:0] r_dat;
    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last    = r_cnt == CNT_LAST;
    assign o_done    = r_cyc && (wb_ack_i || w_last);
    assign o_timeout = r_cyc && !wb_ack_i && w_last;
    assign o_rdata   = o_timeout ? 8'h00 : wb_dat_i;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;

    // Latch a request while idle, drop cyc on ack or timeout; the idle cycle after completion is the mandatory gap
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 3'd0;
            r_dat <= 8'h00;
            r_cnt <= 8'd0;
        end else if (!r_cyc) begin
            if (i_req) begin
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_dat;
                r_cnt <= 8'd0;
            end
        end else if (o_done) begin
            r_cyc <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mpsoc_wb_uart_host.sv
// mpsoc_wb_uart_host: configures a 16550 UART over Wishbone, then moves bytes between stream ports and THR/RBR
module mpsoc_wb_uart_host
    import mpsoc_uart_wb_pkg::*;
#(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VALUE   = 8'h03,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       init_done_o,
    output logic       err_o
);

    host_state_t r_state;
    logic [2:0]  r_step;
    logic        r_lsr_thre;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_tx_ready;
    logic        r_init_done;
    logic        r_err;
    logic        w_done;
    logic        w_timeout;
    logic        w_we;
    logic [2:0]  w_adr;
    logic [7:0]  w_dat;
    logic [7:0]  w_rdata;
    wb_wr_t      w_init;

    assign w_init      = init_write(r_step, DIVISOR, LCR_VALUE);
    assign w_we        = (r_state == ST_INIT) || (r_state == ST_TX_WR);
    assign w_adr       = (r_state == ST_INIT) ? w_init.adr : (r_state == ST_POLL) ? ADR_LSR : ADR_RBR;
    assign w_dat       = (r_state == ST_INIT) ? w_init.dat : (r_state == ST_TX_WR) ? tx_data_i : 8'h00;
    assign wb_sel_o    = 4'b0001;
    assign tx_ready_o  = r_tx_ready;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign init_done_o = r_init_done;
    assign err_o       = r_err;

    mpsoc_wb_uart_host_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .i_req     (1'b1),
        .i_we      (w_we),
        .i_adr     (w_adr),
        .i_dat     (w_dat),
        .o_done    (w_done),
        .o_timeout (w_timeout),
        .o_rdata   (w_rdata),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    // Sequencer: every completed transfer steps the FSM; one LSR sample may serve an RX read then a TX write
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_INIT;
            r_step      <= 3'd0;
            r_lsr_thre  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;
            if (w_timeout) r_err <= 1'b1;
            if (w_done) begin
                case (r_state)
                    ST_INIT: begin
                        r_step <= r_step + 3'd1;
                        if (r_step == INIT_LAST) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_POLL;
                        end
                    end
                    ST_POLL: begin
                        r_lsr_thre <= w_rdata[LSR_THRE];
                        r_state    <= (w_rdata[LSR_DR] && !r_rx_valid) ? ST_RX_RD :
                                      (w_rdata[LSR_THRE] && tx_valid_i) ? ST_TX_WR : ST_POLL;
                    end
                    ST_RX_RD: begin
                        r_rx_data  <= w_rdata;
                        r_rx_valid <= 1'b1;
                        r_state    <= (r_lsr_thre && tx_valid_i) ? ST_TX_WR : ST_POLL;
                    end
                    default: begin
                        r_tx_ready <= 1'b1;
                        r_state    <= ST_POLL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_wb_uart_host.sv
// tb_mpsoc_wb_uart_host: directed scoreboard bench against a behavioural UART register slave
module tb_mpsoc_wb_uart_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       wb_ack_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready = 1'b0;
    logic       init_done_o, err_o;

    int checks = 0;
    int fails = 0;

    logic [11:0] obs_mem [0:4095];
    int          obs_n = 0;
    int          rd = 0;
    logic [7:0]  rbr_mem [0:15];
    int          rbr_wr = 0;
    int          rbr_rd = 0;
    logic [7:0]  lsr_val = 8'h00;
    logic        silent = 1'b0;
    int          tx_cnt = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    mpsoc_wb_uart_host #(.DIVISOR(16'h001B), .LCR_VALUE(8'h03), .ACK_TIMEOUT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready),
        .init_done_o (init_done_o),
        .err_o       (err_o)
    );

    // Slave: single-cycle ack, LSR/RBR read data, logs every acked transfer as {we, adr, data}
    always @(negedge clk) begin
        logic [7:0] d;
        wb_ack_i = 1'b0;
        if (rst_n && wb_cyc_o && wb_stb_o && !silent) begin
            if (wb_we_o) d = wb_dat_o;
            else if (wb_adr_o == 3'd5) d = lsr_val;
            else if (wb_adr_o == 3'd0 && rbr_rd != rbr_wr) begin
                d = rbr_mem[rbr_rd % 16];
                rbr_rd++;
            end else d = 8'h00;
            wb_dat_i = d;
            wb_ack_i = 1'b1;
            obs_mem[obs_n % 4096] = {wb_we_o, wb_adr_o, d};
            obs_n++;
        end
        if (tx_ready_o) tx_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_check(input string tag);
        int k = 0;
        logic [11:0] e, g;
        while (obs_n - rd < exp_q.size() && k < 200) begin
            tick(1);
            k++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd < obs_n) ? obs_mem[rd % 4096] : 12'hxxx;
            rd++;
            check(tag, {20'd0, g}, {20'd0, e});
        end
    endtask

    task automatic wait_cyc(input logic v, input string tag);
        int k = 0;
        while (wb_cyc_o !== v && k < 50) begin
            tick(1);
            k++;
        end
        check(tag, wb_cyc_o, v);
    endtask

    task automatic wait_rx(input logic v, input string tag);
        int k = 0;
        while (rx_valid_o !== v && k < 200) begin
            tick(1);
            k++;
        end
        check(tag, rx_valid_o, v);
    endtask

    task automatic wait_tx(input string tag);
        int k = 0;
        while (tx_ready_o !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        check(tag, tx_ready_o, 1);
    endtask

    initial begin
        int n, nb, txb;
        tick(2);
        check("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, tx_ready_o, rx_valid_o, rx_data_o, init_done_o, err_o}, 0);
        check("reset_sel", wb_sel_o, 4'b0001);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!init_done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("init_cycles", n, 12);
        exp_q.push_back({1'b1, 3'd3, 8'h83});
        exp_q.push_back({1'b1, 3'd0, 8'h1B});
        exp_q.push_back({1'b1, 3'd1, 8'h00});
        exp_q.push_back({1'b1, 3'd3, 8'h03});
        exp_q.push_back({1'b1, 3'd2, 8'h07});
        exp_q.push_back({1'b1, 3'd1, 8'h00});
        exp_q.push_back({1'b0, 3'd5, 8'h00});
        sb_check("init_seq");
        check("init_done", init_done_o, 1);

        tick(1);
        rd = obs_n;
        txb = tx_cnt;
        lsr_val = 8'h60;
        tx_data = 8'h55;
        tx_valid = 1'b1;
        exp_q.push_back({1'b0, 3'd5, 8'h60});
        exp_q.push_back({1'b1, 3'd0, 8'h55});
        wait_tx("tx_ready_seen");
        tx_valid = 1'b0;
        lsr_val = 8'h00;
        sb_check("tx_seq");
        tick(4);
        check("tx_pulses", tx_cnt - txb, 1);

        rd = obs_n;
        rbr_mem[rbr_wr % 16] = 8'hA5;
        rbr_wr++;
        rbr_mem[rbr_wr % 16] = 8'h3C;
        rbr_wr++;
        lsr_val = 8'h01;
        exp_q.push_back({1'b0, 3'd5, 8'h01});
        exp_q.push_back({1'b0, 3'd0, 8'hA5});
        wait_rx(1'b1, "rx1_valid");
        check("rx1_data", rx_data_o, 8'hA5);
        sb_check("rx1_seq");
        tick(20);
        n = 0;
        for (int i = rd; i < obs_n; i++) if (obs_mem[i % 4096][10:8] == 3'd0) n++;
        check("rx_backpressure_reads", n, 0);
        check("rx1_hold", {rx_valid_o, rx_data_o}, {1'b1, 8'hA5});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("rx1_clear", rx_valid_o, 0);
        wait_rx(1'b1, "rx2_valid");
        lsr_val = 8'h00;
        check("rx2_data", rx_data_o, 8'h3C);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(3);

        rd = obs_n;
        rbr_mem[rbr_wr % 16] = 8'h77;
        rbr_wr++;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        lsr_val = 8'h61;
        exp_q.push_back({1'b0, 3'd5, 8'h61});
        exp_q.push_back({1'b0, 3'd0, 8'h77});
        exp_q.push_back({1'b1, 3'd0, 8'hC3});
        exp_q.push_back({1'b0, 3'd5, 8'h00});
        wait_tx("sim_tx_ready");
        tx_valid = 1'b0;
        lsr_val = 8'h00;
        sb_check("sim_seq");
        check("sim_rx_data", {rx_valid_o, rx_data_o}, {1'b1, 8'h77});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;

        check("pre_timeout_err", err_o, 0);
        wait_cyc(1'b0, "to_idle");
        silent = 1'b1;
        wait_cyc(1'b1, "to_issue");
        n = 0;
        do begin
            tick(1);
            n++;
        end while (wb_cyc_o && n < 50);
        check("to_length", n, 8);
        check("to_err_set", err_o, 1);
        wait_cyc(1'b1, "to_continue");
        tick(10);
        silent = 1'b0;
        nb = obs_n;
        tick(20);
        check("to_resume", obs_n > nb, 1);
        check("err_sticky", err_o, 1);

        silent = 1'b1;
        wait_cyc(1'b1, "rst_issue");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_cyc", {wb_cyc_o, wb_stb_o}, 0);
        check("rst_async_flags", {init_done_o, err_o, tx_ready_o, rx_valid_o}, 0);
        silent = 1'b0;
        tick(2);
        rd = obs_n;
        exp_q.push_back({1'b1, 3'd3, 8'h83});
        exp_q.push_back({1'b1, 3'd0, 8'h1B});
        @(negedge clk);
        rst_n = 1'b1;
        sb_check("reinit_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
